// File: rtl/nes_poll_ctrl.sv
// NES controller poll sequencer: drives latch/clock pins, strobes the bit sampler
// and the word latch, and issues periodic or on-demand polls.
module nes_poll_ctrl #(
    parameter int HALF_PERIOD   = 6,
    parameter int POLL_INTERVAL = 166667
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       auto_en,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic       button_en,
    output logic       finished,
    output logic       busy,
    output logic [2:0] bit_idx
);

    // state | meaning
    // IDLE  | no poll running, waiting for start/tick/pending
    // LATCH | latch pin high for two half-periods
    // LOW   | clock pin low; sample strobe on its last cycle
    // HIGH  | clock pin high between bits
    // DONE  | one-cycle finished strobe, may chain straight into LATCH
    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    localparam int PW = $clog2(2 * HALF_PERIOD);
    localparam int IW = $clog2(POLL_INTERVAL);
    localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_PERIOD - 1);
    localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_PERIOD - 1);
    localparam logic [IW-1:0] IVL_LAST   = IW'(POLL_INTERVAL - 1);

    state_t        state, state_next;
    logic [PW-1:0] phase, phase_next;
    logic [2:0]    bit_next;
    logic [IW-1:0] ivl;
    logic          pending, pending_next;
    logic          tick;
    logic          request;
    logic          take;

    assign tick    = auto_en && (ivl == IVL_LAST);
    assign request = start || tick || pending;

    always_ff @(posedge clk) begin
        if (rst || !auto_en) begin
            ivl <= '0;
        end else if (ivl == IVL_LAST) begin
            ivl <= '0;
        end else begin
            ivl <= ivl + IW'(1);
        end
    end

    always_comb begin
        state_next = state;
        bit_next   = bit_idx;
        take       = 1'b0;
        case (state)
            S_IDLE: begin
                if (request) begin
                    state_next = S_LATCH;
                    take       = 1'b1;
                end
            end
            S_LATCH: begin
                if (phase == LATCH_LAST) begin
                    state_next = S_LOW;
                end
            end
            S_LOW: begin
                if (phase == HALF_LAST) begin
                    state_next = (bit_idx == 3'd7) ? S_DONE : S_HIGH;
                end
            end
            S_HIGH: begin
                if (phase == HALF_LAST) begin
                    state_next = S_LOW;
                    bit_next   = bit_idx + 3'd1;
                end
            end
            S_DONE: begin
                bit_next = 3'd0;
                if (request) begin
                    state_next = S_LATCH;
                    take       = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                bit_next   = 3'd0;
            end
        endcase

        // Phase restarts on every state change; IDLE parks it at zero.
        if (state_next != state || state_next == S_IDLE) begin
            phase_next = '0;
        end else begin
            phase_next = phase + PW'(1);
        end

        if (take) begin
            pending_next = 1'b0;
        end else if ((start || tick) && state != S_IDLE) begin
            pending_next = 1'b1;
        end else begin
            pending_next = pending;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            phase   <= '0;
            bit_idx <= 3'd0;
            pending <= 1'b0;
        end else begin
            state   <= state_next;
            phase   <= phase_next;
            bit_idx <= bit_next;
            pending <= pending_next;
        end
    end

    assign nes_latch = (state == S_LATCH);
    assign nes_clk   = (state != S_LOW);
    assign button_en = (state == S_LOW) && (phase == HALF_LAST);
    assign finished  = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule
